// File: rtl/multicycle_control.sv
// Multicycle control unit for the CalcuTEC datapath.
// Each instruction moves through FETCH -> DECODE -> EXEC -> MEM -> WB.
// The unit keeps its own NZCV flag register and evaluates the condition field.
// It drives the datapath selects, the ALU control and the write strobes.
// Optional feature: define MUL_MULTICYCLE_EN to keep MUL in EXEC for
// MUL_CYCLES cycles, timed by a down-counter. With the macro undefined,
// MUL completes in a single EXEC cycle and no counter is built.
module multicycle_control #(
  parameter int ALU_CTRL_W = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [1:0]            sh,
  input  logic [3:0]            alu_flags,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  pc_we,
  output logic                  sel_PC,
  output logic                  sel_dirA,
  output logic [1:0]            imm_src,
  output logic                  sel_B,
  output logic                  sel_dest,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  reg_wr,
  output logic [3:0]            flags_q,
  output logic                  illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_LSL = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_LSR = ALU_CTRL_W'(5);

  // An out-of-range MUL_CYCLES shows up as this named block in the elaborated hierarchy.
  if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_mul_cycles_out_of_range
  end

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cond_q;
  logic [1:0] op_q;
  logic [5:0] funct_q;
  logic [1:0] sh_q;

  logic                  cond_pass;
  logic                  dp_valid;
  logic                  dp_is_mul;
  logic [ALU_CTRL_W-1:0] dp_alu;
  logic                  exec_last;
  logic                  flag_capture;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so it is tested inside the clocked block and not in the
    // sensitivity list. Every register is given a defined reset value.
    if (!rst_n) begin
      // NOTE: sequential state is updated with non-blocking assignments, so that every flop
      // samples its value from before the clock edge.
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction latch: captures the fields on the FETCH handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cond_q  <= '0;
      op_q    <= '0;
      funct_q <= '0;
      sh_q    <= '0;
    end else if (state_q == S_FETCH && instr_valid) begin
      cond_q  <= cond;
      op_q    <= op;
      funct_q <= funct;
      sh_q    <= sh;
    end
  end

`ifdef MUL_MULTICYCLE_EN
  logic [3:0] mul_cnt_q;

  // MUL down-counter: loaded in DECODE, counts down through EXEC; zero marks the last cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_cnt_q <= '0;
    end else if (state_q == S_DECODE) begin
      mul_cnt_q <= 4'(MUL_CYCLES - 1);
    end else if (state_q == S_EXEC && mul_cnt_q != 4'd0) begin
      mul_cnt_q <= mul_cnt_q - 4'd1;
    end
  end

  // A MUL leaves EXEC only when the counter has run out; every other op leaves after one cycle.
  assign exec_last = !(op_q == OP_DP && dp_is_mul) || (mul_cnt_q == 4'd0);
`else
  // Every op, MUL included, spends exactly one cycle in EXEC.
  assign exec_last = 1'b1;
`endif

  // Flags are written only when a valid data-proc op with S=1 leaves EXEC.
  assign flag_capture = (state_q == S_EXEC) && (op_q == OP_DP) && dp_valid &&
                        funct_q[0] && exec_last;

  // Architectural NZCV register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flag_capture) begin
      flags_q <= alu_flags;
    end
  end

  // Evaluate the condition field against the stored flags {V,C,N,Z}.
  always_comb begin
    logic z, n, c, v;
    z = flags_q[0];
    n = flags_q[1];
    c = flags_q[2];
    v = flags_q[3];
    // NOTE: every combinational output gets a default first, so no path through the block can
    // leave it unassigned and infer a latch.
    cond_pass = 1'b1;
    unique case (cond_q)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = !z;
      4'd2:    cond_pass = c;
      4'd3:    cond_pass = !c;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = !n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = !v;
      4'd8:    cond_pass = !z && c;
      4'd9:    cond_pass = z || !c;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = !z && (n == v);
      4'd13:   cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  end

  // Map the data-proc opcode to an ALU operation; unknown opcodes are flagged as not valid.
  always_comb begin
    dp_valid  = 1'b1;
    dp_is_mul = 1'b0;
    dp_alu    = ALU_ADD;
    unique case (funct_q[4:1])
      4'd0: begin
        dp_alu    = ALU_MUL;
        dp_is_mul = 1'b1;
      end
      4'd2:  dp_alu = ALU_SUB;
      4'd4:  dp_alu = ALU_ADD;
      4'd12: dp_alu = ALU_OR;
      4'd13: dp_alu = (sh_q == 2'd1) ? ALU_LSR : ALU_LSL;
      default: begin
        dp_valid = 1'b0;
        dp_alu   = ALU_ADD;
      end
    endcase
  end

  // Next-state and Moore outputs. The only Mealy term is the store pc_we, which is qualified
  // by mem_ack.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_we       = 1'b0;
    sel_PC      = 1'b0;
    sel_dirA    = 1'b0;
    imm_src     = 2'd0;
    sel_B       = 1'b0;
    sel_dest    = 1'b0;
    alu_ctrl    = ALU_ADD;
    reg_wr      = 1'b0;
    illegal     = 1'b0;

    // The datapath selects depend only on the latched instruction, so they stay constant
    // from EXEC through WB.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      unique case (op_q)
        OP_DP: begin
          sel_B    = funct_q[5];
          sel_dirA = 1'b1;
          sel_dest = 1'b1;
          imm_src  = 2'd0;
          alu_ctrl = dp_alu;
        end
        OP_MEM: begin
          sel_B    = funct_q[5];
          sel_dirA = 1'b0;
          imm_src  = 2'd1;
          alu_ctrl = ALU_ADD;
        end
        OP_BR: begin
          sel_B    = 1'b1;
          imm_src  = 2'd2;
          alu_ctrl = ALU_ADD;
        end
        default: begin
          sel_B = 1'b0;
        end
      endcase
    end

    unique case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_pass) begin
          // A failed condition retires the instruction as a plain PC+4 step.
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else if (op_q == OP_ILL) begin
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_DP: begin
            if (!dp_valid) begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end else if (exec_last) begin
              state_d = S_WB;
            end
          end
          OP_MEM: state_d = S_MEM;
          OP_BR: begin
            sel_PC  = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = !funct_q[0];
        if (mem_ack) begin
          if (funct_q[0]) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Each instruction is issued and then traced cycle by cycle. The trace is compared with a
// reference model that predicts latency, strobes, ALU selects and flags from the
// instruction-level rules.
module tb_multicycle_control;

  localparam int ALU_CTRL_W = 3;
  localparam int MUL_CYCLES = 4;
`ifdef MUL_MULTICYCLE_EN
  localparam int MUL_EXEC = MUL_CYCLES;
`else
  localparam int MUL_EXEC = 1;
`endif
  localparam int MAX_CYC = 64;

  logic                  clk;
  logic                  rst_n;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [3:0]            cond;
  logic [1:0]            op;
  logic [5:0]            funct;
  logic [1:0]            sh;
  logic [3:0]            alu_flags;
  logic                  mem_ack;
  logic                  mem_req;
  logic                  mem_we;
  logic                  pc_we;
  logic                  sel_PC;
  logic                  sel_dirA;
  logic [1:0]            imm_src;
  logic                  sel_B;
  logic                  sel_dest;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  reg_wr;
  logic [3:0]            flags_q;
  logic                  illegal;

  multicycle_control #(.ALU_CTRL_W(ALU_CTRL_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cond(cond), .op(op), .funct(funct), .sh(sh), .alu_flags(alu_flags), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we), .sel_PC(sel_PC), .sel_dirA(sel_dirA),
    .imm_src(imm_src), .sel_B(sel_B), .sel_dest(sel_dest), .alu_ctrl(alu_ctrl),
    .reg_wr(reg_wr), .flags_q(flags_q), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [3:0] m_flags;  // model of the architectural flags

  // Per-cycle trace of the last instruction; index 0 is the accepting FETCH cycle.
  logic       obs_pc_we   [MAX_CYC];
  logic       obs_reg_wr  [MAX_CYC];
  logic       obs_illegal [MAX_CYC];
  logic       obs_sel_pc  [MAX_CYC];
  logic       obs_mem_req [MAX_CYC];
  logic       obs_mem_we  [MAX_CYC];
  logic [2:0] obs_alu     [MAX_CYC];
  logic [3:0] flag_hist   [MAX_CYC];
  int         last_lat;

  // Condition rules over flags {V,C,N,Z}.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit z, n, cy, v;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return !z && cy;
      4'd9:  return z || !cy;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Data-proc opcode to ALU code; -1 for an unknown opcode.
  function automatic int alu_for(input logic [3:0] opc, input logic [1:0] s);
    case (opc)
      4'd0:  return 2;
      4'd2:  return 1;
      4'd4:  return 0;
      4'd12: return 3;
      4'd13: return (s == 2'd1) ? 5 : 4;
      default: return -1;
    endcase
  endfunction

  // Issue one instruction, trace it until FETCH returns, and compare against the model.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [1:0] s, input int wait_n, input bit rnd_flags,
                           input logic [3:0] fix_flags, input string name);
    int lat, mem_seen, exec_n, exp_lat, exp_mreq, ac;
    int n_pc, n_wr, n_ill, n_mreq, n_mwe_bad, n_alu_bad;
    bit pass, exp_wr, exp_ill, exp_selpc;
    logic [3:0] exp_flags;

    @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_at_issue: got %b want 1", name, instr_ready);
    end
    instr_valid = 1'b1;
    cond = c; op = o; funct = f; sh = s;
    alu_flags = rnd_flags ? 4'($urandom) : fix_flags;
    flag_hist[0] = alu_flags;
    for (int j = 0; j < MAX_CYC; j++) begin
      obs_pc_we[j] = 0; obs_reg_wr[j] = 0; obs_illegal[j] = 0; obs_sel_pc[j] = 0;
      obs_mem_req[j] = 0; obs_mem_we[j] = 0; obs_alu[j] = '0;
    end
    lat = -1;
    mem_seen = 0;
    for (int k = 1; k < MAX_CYC && lat < 0; k++) begin
      @(negedge clk);
      // Scramble the fetch inputs so that the DUT must rely on its latch.
      instr_valid = 1'b0;
      cond = 4'($urandom); op = 2'($urandom); funct = 6'($urandom); sh = 2'($urandom);
      alu_flags = rnd_flags ? 4'($urandom) : fix_flags;
      flag_hist[k] = alu_flags;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        mem_seen++;
        if (mem_seen == wait_n + 1) mem_ack = 1'b1;
      end
      #1;
      if (instr_ready === 1'b1) begin
        lat = k;
      end else begin
        obs_pc_we[k] = pc_we; obs_reg_wr[k] = reg_wr; obs_illegal[k] = illegal;
        obs_sel_pc[k] = sel_PC; obs_mem_req[k] = mem_req; obs_mem_we[k] = mem_we;
        obs_alu[k] = alu_ctrl;
      end
    end
    mem_ack = 1'b0;
    last_lat = lat;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no return to FETCH within %0d cycles", name, MAX_CYC);
      return;
    end

    // Reference model.
    pass = cond_ok(c, m_flags);
    ac = alu_for(f[4:1], s);
    exec_n = 0; exp_wr = 0; exp_ill = 0; exp_selpc = 0; exp_mreq = 0;
    exp_flags = m_flags;
    if (!pass) begin
      exp_lat = 2;
    end else if (o == 2'd3) begin
      exp_lat = 2; exp_ill = 1;
    end else if (o == 2'd2) begin
      exp_lat = 3; exp_selpc = 1;
    end else if (o == 2'd1) begin
      exp_mreq = wait_n + 1;
      exp_wr = f[0];
      exp_lat = 3 + exp_mreq + (f[0] ? 1 : 0);
    end else if (ac < 0) begin
      exp_lat = 3;
    end else begin
      exec_n = (f[4:1] == 4'd0) ? MUL_EXEC : 1;
      exp_lat = exec_n + 3;
      exp_wr = 1;
      if (f[0]) exp_flags = flag_hist[1 + exec_n];
    end

    n_pc = 0; n_wr = 0; n_ill = 0; n_mreq = 0; n_mwe_bad = 0; n_alu_bad = 0;
    for (int j = 1; j < lat; j++) begin
      n_pc += int'(obs_pc_we[j]);
      n_wr += int'(obs_reg_wr[j]);
      n_ill += int'(obs_illegal[j]);
      n_mreq += int'(obs_mem_req[j]);
      if (obs_mem_req[j] && (obs_mem_we[j] !== !f[0])) n_mwe_bad++;
    end
    for (int j = 2; j < 2 + exec_n; j++)
      if (obs_alu[j] !== 3'(ac)) n_alu_bad++;

    n_cmp++;
    if (lat != exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (n_pc != 1 || obs_pc_we[lat-1] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s pc_we: got %0d pulses last=%b want 1 pulse on last cycle",
               name, n_pc, obs_pc_we[lat-1]);
    end
    n_cmp++;
    if (n_wr != int'(exp_wr) || obs_reg_wr[lat-1] !== exp_wr) begin
      n_bad++;
      $display("FAIL %s reg_wr: got %0d pulses last=%b want %0d", name, n_wr,
               obs_reg_wr[lat-1], exp_wr);
    end
    n_cmp++;
    if (n_ill != int'(exp_ill)) begin
      n_bad++; $display("FAIL %s illegal: got %0d pulses want %0d", name, n_ill, exp_ill);
    end
    n_cmp++;
    if (obs_sel_pc[lat-1] !== exp_selpc) begin
      n_bad++;
      $display("FAIL %s sel_PC: got %b want %b", name, obs_sel_pc[lat-1], exp_selpc);
    end
    n_cmp++;
    if (n_mreq != exp_mreq || n_mwe_bad != 0) begin
      n_bad++;
      $display("FAIL %s mem_req: got %0d cycles (%0d bad mem_we) want %0d", name, n_mreq,
               n_mwe_bad, exp_mreq);
    end
    if (exec_n > 0) begin
      n_cmp++;
      if (n_alu_bad != 0) begin
        n_bad++;
        $display("FAIL %s alu_ctrl: %0d EXEC cycles wrong, want %0d", name, n_alu_bad, ac);
      end
    end
    m_flags = exp_flags;
    n_cmp++;
    if (flags_q !== m_flags) begin
      n_bad++; $display("FAIL %s flags_q: got %b want %b", name, flags_q, m_flags);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    cond = '0; op = '0; funct = '0; sh = '0; alu_flags = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_flags = 4'b0000;
    #1;
    n_cmp++;
    if (instr_ready !== 1'b1 || flags_q !== 4'b0000 || pc_we !== 1'b0 || reg_wr !== 1'b0 ||
        mem_req !== 1'b0 || illegal !== 1'b0 || sel_PC !== 1'b0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b flags=%b pc_we=%b reg_wr=%b mem_req=%b want 1/0000/0/0/0",
               instr_ready, flags_q, pc_we, reg_wr, mem_req);
    end
  endtask

  task automatic test_add_s();
    run_instr(4'd14, 2'd0, 6'b001001, 2'd0, 0, 1'b0, 4'b0001, "add_s");
    n_cmp++;
    if (obs_reg_wr[3] !== 1'b1 || obs_pc_we[3] !== 1'b1 || flags_q !== 4'b0001) begin
      n_bad++;
      $display("FAIL add_s_timing: reg_wr@3=%b pc_we@3=%b flags=%b want 1/1/0001",
               obs_reg_wr[3], obs_pc_we[3], flags_q);
    end
  endtask

  task automatic test_beq();
    run_instr(4'd0, 2'd2, 6'b100000, 2'd0, 0, 1'b1, 4'b0000, "beq_taken");
    n_cmp++;
    if (obs_sel_pc[2] !== 1'b1 || obs_pc_we[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL beq_taken_exec: sel_PC=%b pc_we=%b want 1/1", obs_sel_pc[2], obs_pc_we[2]);
    end
    run_instr(4'd14, 2'd0, 6'b001001, 2'd0, 0, 1'b0, 4'b0000, "clear_z");
    run_instr(4'd0, 2'd2, 6'b100000, 2'd0, 0, 1'b1, 4'b0000, "beq_not_taken");
    n_cmp++;
    if (last_lat != 2 || obs_pc_we[1] !== 1'b1 || obs_sel_pc[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL beq_not_taken_decode: lat=%0d pc_we=%b sel_PC=%b want 2/1/0",
               last_lat, obs_pc_we[1], obs_sel_pc[1]);
    end
  endtask

  task automatic test_load();
    int n;
    run_instr(4'd14, 2'd1, 6'b100001, 2'd0, 3, 1'b1, 4'b0000, "load_wait3");
    n = 0;
    for (int j = 0; j < MAX_CYC; j++) n += int'(obs_mem_req[j]);
    n_cmp++;
    if (n != 4 || obs_reg_wr[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL load_wait3_shape: mem_req=%0d cycles reg_wr@7=%b want 4/1", n, obs_reg_wr[7]);
    end
  endtask

  task automatic test_store_reset();
    bit seen;
    run_instr(4'd14, 2'd1, 6'b000000, 2'd0, 1, 1'b1, 4'b0000, "store_wait1");
    n_cmp++;
    if (obs_mem_we[3] !== 1'b1 || last_lat != 5) begin
      n_bad++;
      $display("FAIL store_shape: mem_we@3=%b lat=%0d want 1/5", obs_mem_we[3], last_lat);
    end
    run_instr(4'd14, 2'd0, 6'b001001, 2'd0, 0, 1'b0, 4'b1010, "set_flags");
    @(negedge clk);
    instr_valid = 1'b1; cond = 4'd14; op = 2'd1; funct = 6'b000000; sh = 2'd0; mem_ack = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL store_reach_mem: got no mem_req want mem_req within 10 cycles");
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b1 || mem_req !== 1'b0 || pc_we !== 1'b0 || flags_q !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_mid_mem: ready=%b mem_req=%b pc_we=%b flags=%b want 1/0/0/0000",
               instr_ready, mem_req, pc_we, flags_q);
    end
    rst_n = 1'b1;
    m_flags = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (pc_we !== 1'b0 || reg_wr !== 1'b0 || instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL after_reset_quiet: pc_we=%b reg_wr=%b ready=%b want 0/0/1",
               pc_we, reg_wr, instr_ready);
    end
  endtask

  task automatic test_mul();
    run_instr(4'd14, 2'd0, 6'b000001, 2'd0, 0, 1'b1, 4'b0000, "mul_s");
    n_cmp++;
    if (obs_alu[2] !== 3'd2 || obs_reg_wr[MUL_EXEC + 2] !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_shape: alu@2=%0d reg_wr@%0d=%b want 2/1", obs_alu[2], MUL_EXEC + 2,
               obs_reg_wr[MUL_EXEC + 2]);
    end
  endtask

  task automatic test_illegal();
    run_instr(4'd14, 2'd3, 6'b010101, 2'd0, 0, 1'b1, 4'b0000, "illegal");
    n_cmp++;
    if (obs_illegal[1] !== 1'b1) begin
      n_bad++; $display("FAIL illegal_pulse: got %b want 1 in DECODE", obs_illegal[1]);
    end
  endtask

  task automatic test_random();
    int codes[6] = '{0, 2, 4, 12, 13, 7};
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [3:0] c, opc;
      logic [1:0] o;
      r = $urandom_range(0, 9);
      o = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      c = ($urandom_range(0, 1) == 0) ? 4'd14 : 4'($urandom);
      opc = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(codes[$urandom_range(0, 5)]);
      run_instr(c, o, {1'($urandom), opc, 1'($urandom)}, 2'($urandom),
                int'($urandom_range(0, 3)), 1'b1, 4'b0000, "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_flags = 4'b0000;
    last_lat = 0;
    test_reset();
    test_add_s();
    test_beq();
    test_load();
    test_store_reset();
    test_mul();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
